mem_copy_master: RTL and testbench
==================================

MEM_COPY_MASTER -- requirements
Module: mem_copy_master

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 16, width of the word-count input.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum cycles one request may wait for mem_ready; 0 disables the timeout.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, single-cycle request to begin a copy.
REQ-006 SHALL have port src_addr, input, 32, byte address of the first source word.
REQ-007 SHALL have port dst_addr, input, 32, byte address of the first destination word.
REQ-008 SHALL have port len_words, input, LEN_WIDTH, number of 32-bit words to copy.
REQ-009 SHALL have port busy, output, 1, high from the accepted start until done.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port error, output, 1, sticky abort flag, cleared by the next accepted start.
REQ-012 SHALL have ports mem_valid (output, 1), mem_addr (output, 32), mem_wstrb (output, 4), mem_wdata (output, 32), mem_ready (input, 1), mem_rdata (input, 32) and access_fault (input, 1), forming the initiator side of the system valid/ready memory bus.

Function
REQ-013 SHALL accept start only in IDLE; start while busy is ignored with no effect.
REQ-014 SHALL latch src_addr and dst_addr with bits [1:0] forced to 0, and latch len_words, on the accepted-start edge.
REQ-015 SHALL implement states IDLE, RD, RD_GAP, WR, WR_GAP and FIN.
REQ-016 SHALL transition IDLE->RD on start with len_words!=0, and IDLE->FIN on start with len_words==0, issuing no bus request in the zero-length case.
REQ-017 SHALL assert mem_valid in the first cycle of RD or WR, then hold mem_valid, mem_addr, mem_wstrb and mem_wdata stable until mem_ready is sampled high.
REQ-018 SHALL treat a cycle with mem_valid and mem_ready both high as transfer completion; mem_ready while mem_valid is low is ignored.
REQ-019 SHALL drive mem_valid low for exactly one cycle (the *_GAP state) after each completed transfer, so no two requests are back-to-back.
REQ-020 SHALL in RD drive mem_wstrb=4'h0 and mem_addr=current source, and on completion capture mem_rdata into a data register, then go RD->RD_GAP->WR.
REQ-021 SHALL in WR drive mem_wstrb=4'hF, mem_addr=current destination and mem_wdata=the captured word.
REQ-022 SHALL on WR completion add 4 to both addresses (modulo 2^32, wrapping silently), decrement the remaining count, and go WR->WR_GAP->RD if the count is nonzero, else WR->WR_GAP->FIN.
REQ-023 SHALL in FIN pulse done high for one cycle, deassert busy in that same cycle, and return to IDLE.
REQ-024 SHALL, when access_fault is high in a completion cycle, discard that transfer, set error, drop mem_valid on the next edge and go to FIN.
REQ-025 SHALL, when TIMEOUT_CYCLES!=0 and mem_valid has been high for TIMEOUT_CYCLES cycles without mem_ready, set error, drop mem_valid and go to FIN.
REQ-026 SHALL restart the timeout counter at each new request.
REQ-027 SHALL keep mem_valid, mem_wstrb and done at 0 in IDLE, and hold mem_addr and mem_wdata at their last values there.
REQ-028 SHALL have a fault-free copy of N words take exactly 6*N+2 cycles from the start edge to the done pulse when mem_ready is returned one cycle after mem_valid rises.

Reset
REQ-029 SHALL on reset go to IDLE and clear busy, done, error, mem_valid, mem_wstrb, mem_addr, mem_wdata, the data register, the counters and the latched addresses to 0.
REQ-030 SHALL honour reset during any state, with mem_valid low at the first edge where reset is sampled high and no further bus request issued.
REQ-031 SHALL ignore start while reset is high.

Verification
REQ-032 SHALL cover: preload src 0x100..0x10C with 0x11111111..0x44444444, start src=0x100 dst=0x200 len=4 -> 0x200..0x20C hold the same words, done after 26 cycles, error=0.
REQ-033 SHALL cover: start with len=0 -> done 2 cycles after start, mem_valid never high.
REQ-034 SHALL cover: responder inserting 0-5 random wait states and src=0x103 -> addresses aligned to 0x100, each request held stable until ready, one idle cycle between requests.
REQ-035 SHALL cover: access_fault=1 on the second read -> error=1, done pulses, exactly one write issued.
REQ-036 SHALL cover: mem_ready held low with TIMEOUT_CYCLES=8 -> error=1 and mem_valid low after 8 cycles, then done.
REQ-037 SHALL cover: reset asserted mid-WR -> mem_valid=0 and busy=0 next edge; a following start len=1 completes normally with error=0.

Source files
------------

// File: rtl/mem_copy_master.sv
// mem_copy_master: word-by-word copy engine on a valid/ready memory bus.
// Each word is read then written, with one idle bus cycle after every transfer.
module mem_copy_master #(
   parameter int unsigned LEN_WIDTH      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [31:0]          src_addr,
   input  logic [31:0]          dst_addr,
   input  logic [LEN_WIDTH-1:0] len_words,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic                 mem_valid,
   output logic [31:0]          mem_addr,
   output logic [3:0]           mem_wstrb,
   output logic [31:0]          mem_wdata,
   input  logic                 mem_ready,
   input  logic [31:0]          mem_rdata,
   input  logic                 access_fault
);

   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RD_GAP,
      WR,
      WR_GAP,
      FIN
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic [31:0]          src_q;
   logic [31:0]          dst_q;
   logic [LEN_WIDTH-1:0] cnt_q;
   logic [31:0]          data_q;
   logic [31:0]          addr_q;
   logic                 err_q;
   logic [TW-1:0]        timer_q;

   logic                 accept;
   logic                 xfer;
   logic                 timeout;

   assign accept  = (state_q == IDLE) && start;
   assign xfer    = mem_valid && mem_ready;
   // timer_q counts completed valid-without-ready cycles of the current request
   assign timeout = (TIMEOUT_CYCLES != 0) && mem_valid && !mem_ready && (timer_q == T_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (len_words == '0) ? FIN : RD;
            end
         end
         RD: begin
            if (xfer) begin
               state_d = access_fault ? FIN : RD_GAP;
            end else if (timeout) begin
               state_d = FIN;
            end
         end
         RD_GAP: state_d = WR;
         WR: begin
            if (xfer) begin
               state_d = access_fault ? FIN : WR_GAP;
            end else if (timeout) begin
               state_d = FIN;
            end
         end
         WR_GAP:  state_d = (cnt_q == '0) ? FIN : RD;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_q)
         RD: begin
            mem_valid = 1'b1;
            busy      = 1'b1;
         end
         WR: begin
            mem_valid = 1'b1;
            mem_wstrb = 4'hF;
            busy      = 1'b1;
         end
         RD_GAP, WR_GAP: busy = 1'b1;
         FIN:            done = 1'b1;
         default: ;
      endcase
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = data_q;
   assign error     = err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         addr_q  <= '0;
         err_q   <= 1'b0;
         timer_q <= '0;
      end else begin
         if (accept) begin
            src_q <= src_addr & 32'hFFFF_FFFC;
            dst_q <= dst_addr & 32'hFFFF_FFFC;
            cnt_q <= len_words;
            err_q <= 1'b0;
            if (len_words != '0) begin
               addr_q <= src_addr & 32'hFFFF_FFFC;
            end
         end

         if (mem_valid && !mem_ready) begin
            timer_q <= timer_q + TW'(1);
         end else begin
            timer_q <= '0;
         end

         if ((xfer && access_fault) || timeout) begin
            err_q <= 1'b1;
         end

         // a faulted transfer leaves data, addresses and count untouched
         if (xfer && !access_fault) begin
            if (state_q == RD) begin
               data_q <= mem_rdata;
            end else begin
               src_q <= src_q + 32'd4;
               dst_q <= dst_q + 32'd4;
               cnt_q <= cnt_q - LEN_WIDTH'(1);
            end
         end

         // the gap cycle preloads the address of the next request
         if (state_q == RD_GAP) begin
            addr_q <= dst_q;
         end
         if ((state_q == WR_GAP) && (cnt_q != '0)) begin
            addr_q <= src_q;
         end
      end
   end

endmodule

// File: tb/tb_mem_copy_master.sv
// Bench for mem_copy_master: random-wait memory responder plus a sequential
// copy model over a 4 KB aliased memory image.
module tb_mem_copy_master;

   localparam int unsigned LW = 16;
   localparam int unsigned TO = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [31:0]   src_addr;
   logic [31:0]   dst_addr;
   logic [LW-1:0] len_words;
   logic          busy;
   logic          done;
   logic          error;
   logic          mem_valid;
   logic [31:0]   mem_addr;
   logic [3:0]    mem_wstrb;
   logic [31:0]   mem_wdata;
   logic          mem_ready = 1'b0;
   logic [31:0]   mem_rdata = '0;
   logic          access_fault = 1'b0;

   always #5 clk = ~clk;

   mem_copy_master #(
      .LEN_WIDTH     (LW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .src_addr    (src_addr),
      .dst_addr    (dst_addr),
      .len_words   (len_words),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .mem_valid   (mem_valid),
      .mem_addr    (mem_addr),
      .mem_wstrb   (mem_wstrb),
      .mem_wdata   (mem_wdata),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .access_fault(access_fault)
   );

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic [31:0] mem     [1024];
   logic [31:0] img     [1024];
   logic [31:0] exp_mem [1024];

   // responder controls, written only by the main sequence
   int unsigned wait_min = 1;
   int unsigned wait_max = 1;
   bit          hold_ready = 1'b0;
   int unsigned fault_rd = 0;
   int unsigned load_gen = 0;

   // responder / monitor bookkeeping, each written by one process only
   int unsigned rd_reqs = 0;
   int unsigned sum_wait = 0;
   int unsigned wr_done = 0;
   int unsigned mem_gen = 0;

   function automatic int unsigned widx(input logic [31:0] a);
      return {22'd0, a[11:2]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // memory side: loads new images and commits completed writes
   always @(posedge clk) begin
      if (load_gen != mem_gen) begin
         mem = img;
         mem_gen = load_gen;
      end else if (!reset && mem_valid && mem_ready && !access_fault && mem_wstrb == 4'hF) begin
         mem[widx(mem_addr)] = mem_wdata;
         wr_done++;
      end
   end

   // responder: random wait states, stability and inter-request gap checks
   bit          active = 1'b0;
   bit          in_run = 1'b0;
   int          wait_left = -1;
   int unsigned low_run = 0;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   bit          r_fault;

   always @(negedge clk) begin
      if (!busy) in_run = 1'b0;
      if (!mem_valid) begin
         mem_ready = 1'b0;
         access_fault = 1'b0;
         mem_rdata = $urandom;
         active = 1'b0;
         if (busy) low_run++;
      end else begin
         if (!active) begin
            active = 1'b1;
            r_addr = mem_addr;
            r_wstrb = mem_wstrb;
            r_wdata = mem_wdata;
            if (in_run) check("gap", 32'(low_run), 32'd1);
            in_run = 1'b1;
            low_run = 0;
            check("align", 32'(mem_addr[1:0]), 32'd0);
            r_fault = 1'b0;
            if (mem_wstrb == 4'h0) begin
               rd_reqs++;
               r_fault = (rd_reqs == fault_rd);
            end else begin
               check("wstrb", 32'(mem_wstrb), 32'hF);
            end
            if (hold_ready) begin
               wait_left = -1;
            end else begin
               wait_left = int'($urandom_range(wait_max, wait_min));
               sum_wait += 32'(wait_left);
            end
         end else begin
            check("hold_addr", mem_addr, r_addr);
            check("hold_wstrb", 32'(mem_wstrb), 32'(r_wstrb));
            check("hold_wdata", mem_wdata, r_wdata);
         end
         if (wait_left == 0) begin
            mem_ready = 1'b1;
            access_fault = r_fault;
            mem_rdata = r_fault ? $urandom : mem[widx(mem_addr)];
            wait_left = -1;
         end else begin
            mem_ready = 1'b0;
            access_fault = 1'b0;
            mem_rdata = $urandom;
            if (wait_left > 0) wait_left--;
         end
      end
   end

   task automatic load_mem();
      load_gen++;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int unsigned n);
      logic [31:0] sa;
      logic [31:0] da;
      sa = s & 32'hFFFF_FFFC;
      da = d & 32'hFFFF_FFFC;
      for (int unsigned i = 0; i < n; i++) begin
         exp_mem[widx(da)] = exp_mem[widx(sa)];
         sa = sa + 32'd4;
         da = da + 32'd4;
      end
   endtask

   task automatic check_mem(input string tag);
      int unsigned bad;
      bad = 0;
      for (int i = 0; i < 1024; i++) begin
         if (mem[i] !== exp_mem[i]) bad++;
      end
      check(tag, 32'(bad), 32'd0);
   endtask

   // cyc counts the start cycle through the done cycle inclusive
   task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int unsigned n,
                           input int unsigned poke_at, output int unsigned cyc,
                           output int unsigned vhigh);
      bit got;
      bit busy_ok;
      @(negedge clk);
      src_addr = s;
      dst_addr = d;
      len_words = LW'(n);
      start = 1'b1;
      cyc = 1;
      vhigh = 0;
      got = 1'b0;
      busy_ok = 1'b1;
      while (!got && cyc < 3000) begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
         if (poke_at != 0 && cyc == poke_at) begin
            start = 1'b1;
            src_addr = 32'h0000_0800;
            dst_addr = 32'h0000_0900;
            len_words = LW'(7);
         end
         if (mem_valid) vhigh++;
         if (done) got = 1'b1;
         else if (!busy) busy_ok = 1'b0;
      end
      check("done_seen", 32'(got), 32'd1);
      check("busy_at_done", 32'(busy), 32'd0);
      check("busy_during_run", 32'(busy_ok), 32'd1);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned cyc;
      int unsigned vh;
      int unsigned w0;
      int unsigned sw0;
      int unsigned n;
      logic [31:0] s;
      logic [31:0] d;
      logic [31:0] last;

      reset = 1'b1;
      start = 1'b0;
      src_addr = '0;
      dst_addr = '0;
      len_words = '0;
      for (int i = 0; i < 1024; i++) img[i] = $urandom;
      load_gen++;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_valid", 32'(mem_valid), 32'd0);
      check("rst_wstrb", 32'(mem_wstrb), 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // directed 4-word copy, fixed one-cycle ready, ignored start mid-run
      img = mem;
      img[widx(32'h100)] = 32'h1111_1111;
      img[widx(32'h104)] = 32'h2222_2222;
      img[widx(32'h108)] = 32'h3333_3333;
      img[widx(32'h10C)] = 32'h4444_4444;
      load_mem();
      exp_mem = img;
      model_copy(32'h100, 32'h200, 4);
      w0 = wr_done;
      run_copy(32'h100, 32'h200, 4, 5, cyc, vh);
      check("copy4_cycles", 32'(cyc), 32'd26);
      check("copy4_error", 32'(error), 32'd0);
      check("copy4_writes", 32'(wr_done - w0), 32'd4);
      check_mem("copy4_mem");
      check("copy4_word3", mem[widx(32'h20C)], 32'h4444_4444);
      check("idle_addr_hold", mem_addr, 32'h0000_020C);
      check("idle_wdata_hold", mem_wdata, 32'h4444_4444);
      check("idle_valid", 32'(mem_valid), 32'd0);
      check("idle_wstrb", 32'(mem_wstrb), 32'd0);

      // zero length
      w0 = wr_done;
      run_copy(32'h300, 32'h400, 0, 0, cyc, vh);
      check("len0_cycles", 32'(cyc), 32'd2);
      check("len0_valid_cycles", 32'(vh), 32'd0);
      check("len0_error", 32'(error), 32'd0);
      check("len0_writes", 32'(wr_done - w0), 32'd0);
      check("len0_addr_hold", mem_addr, 32'h0000_020C);

      // random wait states and addresses, first one unaligned at 0x103
      wait_min = 0;
      wait_max = 5;
      for (int k = 0; k < 6; k++) begin
         s = (k == 0) ? 32'h103 : 32'($urandom_range(32'hFFF, 0));
         d = (k == 0) ? 32'h202 : 32'($urandom_range(32'hFFF, 0));
         n = $urandom_range(6, 1);
         exp_mem = mem;
         model_copy(s, d, n);
         w0 = wr_done;
         sw0 = sum_wait;
         run_copy(s, d, n, 0, cyc, vh);
         check("rand_cycles", 32'(cyc), 32'(2 + 4 * n + (sum_wait - sw0)));
         check("rand_error", 32'(error), 32'd0);
         check("rand_writes", 32'(wr_done - w0), 32'(n));
         check_mem("rand_mem");
         last = (d & 32'hFFFF_FFFC) + 32'(4 * (n - 1));
         check("rand_last_addr", mem_addr, last);
      end
      wait_min = 1;
      wait_max = 1;

      // address wrap at 2^32
      exp_mem = mem;
      model_copy(32'hFFFF_FFF8, 32'hFFFF_FFF4, 4);
      run_copy(32'hFFFF_FFF8, 32'hFFFF_FFF4, 4, 0, cyc, vh);
      check("wrap_cycles", 32'(cyc), 32'd26);
      check("wrap_error", 32'(error), 32'd0);
      check_mem("wrap_mem");
      check("wrap_last_addr", mem_addr, 32'h0000_0000);

      // access fault on the second read
      fault_rd = rd_reqs + 2;
      exp_mem = mem;
      model_copy(32'h300, 32'h380, 1);
      w0 = wr_done;
      run_copy(32'h300, 32'h380, 3, 0, cyc, vh);
      fault_rd = 0;
      check("fault_error", 32'(error), 32'd1);
      check("fault_writes", 32'(wr_done - w0), 32'd1);
      check_mem("fault_mem");

      // ready never returned: timeout after TO cycles of valid
      hold_ready = 1'b1;
      w0 = wr_done;
      run_copy(32'h500, 32'h600, 2, 0, cyc, vh);
      hold_ready = 1'b0;
      check("timeout_valid_cycles", 32'(vh), 32'(TO));
      check("timeout_cycles", 32'(cyc), 32'(TO + 2));
      check("timeout_error", 32'(error), 32'd1);
      check("timeout_writes", 32'(wr_done - w0), 32'd0);
      check("timeout_valid_low", 32'(mem_valid), 32'd0);

      // next start clears the sticky error
      exp_mem = mem;
      model_copy(32'h040, 32'h0C0, 2);
      run_copy(32'h040, 32'h0C0, 2, 0, cyc, vh);
      check("after_to_error", 32'(error), 32'd0);
      check("after_to_cycles", 32'(cyc), 32'd14);
      check_mem("after_to_mem");

      // reset in the middle of a write, start held during reset
      exp_mem = mem;
      w0 = wr_done;
      @(negedge clk);
      src_addr = 32'h700;
      dst_addr = 32'h780;
      len_words = LW'(3);
      start = 1'b1;
      vh = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         vh++;
      end while (!(mem_valid && mem_wstrb == 4'hF) && vh < 100);
      check("rst_reach_wr", 32'(mem_valid && mem_wstrb == 4'hF), 32'd1);
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      check("midrst_valid", 32'(mem_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_addr", mem_addr, 32'd0);
      check("midrst_wdata", mem_wdata, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("start_in_reset_ignored", 32'(busy), 32'd0);
      check("midrst_writes", 32'(wr_done - w0), 32'd0);
      check_mem("midrst_mem");
      model_copy(32'h704, 32'h790, 1);
      run_copy(32'h704, 32'h790, 1, 0, cyc, vh);
      check("post_rst_cycles", 32'(cyc), 32'd8);
      check("post_rst_error", 32'(error), 32'd0);
      check_mem("post_rst_mem");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
